delay_line_uart_tx: RTL and testbench

Serial result transmitter for the delay-line design: accepts a 16-bit measurement word over a valid/ready handshake and sends it off-chip as two back-to-back UART 8N1 frames, low byte first. It sits between the delay-line capture logic and one dedicated output pin of the top-level wrapper. It is the outbound counterpart of the host-facing input interface on `ui_in`.

---
 rtl/delay_line_uart_tx.sv | 118 +++++++++++
 tb/tb_delay_line_uart_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/delay_line_uart_tx.sv
// Serial result transmitter: sends one 16-bit measurement word as two
// back-to-back UART 8N1 frames (low byte first) behind a valid/ready handshake.
module delay_line_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q, state_d;
  logic           byte_q, byte_d;
  logic [2:0]     bit_q, bit_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    shreg_q, shreg_d;
  logic           tx_q, tx_d;
  logic           cnt_done;

  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= 1'b0;
      bit_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // The line value for the next bit period is loaded on the same edge that
  // ends the current one, so o_tx stays a pure flop output. Each completed
  // data bit shifts the word right; after eight shifts the high byte sits in
  // shreg_q[7:0] ready for the second frame.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = START;
          byte_d  = 1'b0;
          bit_d   = '0;
          cnt_d   = '0;
          shreg_d = i_data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_done) begin
          state_d = DATA;
          bit_d   = '0;
          cnt_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[15:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (!byte_q) begin
            state_d = START;
            byte_d  = 1'b1;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = ~o_ready;
  assign o_tx    = tx_q;

endmodule

// File: tb/tb_delay_line_uart_tx.sv
// Bench for delay_line_uart_tx: three instances (4, 2 and 10 clocks per bit)
// checked cycle by cycle against a frame-level model of the serial line.
module tb_delay_line_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        vld [3];
  logic [15:0] dat [3];
  logic        rdy [3];
  logic        tx  [3];
  logic        bsy [3];

  int unsigned cpb_of [3] = '{4, 2, 10};
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  delay_line_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_data(dat[0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(bsy[0])
  );
  delay_line_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_data(dat[1]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(bsy[1])
  );
  delay_line_uart_tx #(.CLKS_PER_BIT(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .i_data(dat[2]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Line level during bit slot pos (0..19) of a word: start, 8 data LSB first, stop.
  function automatic logic exp_bit(input logic [15:0] w, input int unsigned pos);
    logic [7:0]  b;
    int unsigned p;
    b = (pos < 10) ? w[7:0] : w[15:8];
    p = pos % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  task automatic check_idle(input int d, input string tag);
    check($sformatf("%s_tx d%0d", tag, d), tx[d], 1);
    check($sformatf("%s_rdy d%0d", tag, d), rdy[d], 1);
    check($sformatf("%s_busy d%0d", tag, d), bsy[d], 0);
  endtask

  // Presents w at a falling edge; returns at the falling edge after the accept.
  task automatic accept(input int d, input logic [15:0] w);
    int unsigned n;
    n = 0;
    while (!rdy[d] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_wait d%0d", d), rdy[d], 1);
    vld[d] = 1'b1;
    dat[d] = w;
    @(negedge clk);
  endtask

  // Checks slots j=first..last (cycle offsets after the accept edge).
  task automatic check_span(input int d, input logic [15:0] w,
                            input int unsigned first, input int unsigned last);
    int unsigned cpb;
    cpb = cpb_of[d];
    for (int unsigned j = first; j <= last; j++) begin
      check($sformatf("tx d%0d w%04h j%0d", d, w, j), tx[d], exp_bit(w, j / cpb));
      check($sformatf("rdy d%0d w%04h j%0d", d, w, j), rdy[d], 0);
      check($sformatf("busy d%0d w%04h j%0d", d, w, j), bsy[d], 1);
      @(negedge clk);
    end
  endtask

  task automatic send_word(input int d, input logic [15:0] w, input bit scramble);
    accept(d, w);
    vld[d] = 1'b0;
    dat[d] = scramble ? ~w : 16'h0000;
    check_span(d, w, 0, 20 * cpb_of[d] - 1);
    check_idle(d, "end");
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle(i, "reset");
    rst_n = 1'b1;
    @(negedge clk);

    // directed words on the 4-clock instance
    send_word(0, 16'hA55A, 1'b0);
    send_word(0, 16'h0000, 1'b0);
    send_word(0, 16'hFFFF, 1'b0);
    send_word(0, 16'h00FF, 1'b1);

    // held valid: second word accepted right after the one-cycle idle gap
    accept(0, 16'h1234);
    dat[0] = 16'h5678;
    check_span(0, 16'h1234, 0, 79);
    check_idle(0, "gap");
    @(negedge clk);
    vld[0] = 1'b0;
    check_span(0, 16'h5678, 0, 79);
    for (int i = 0; i < 12; i++) begin
      check_idle(0, "after_hold");
      @(negedge clk);
    end

    // reset in the middle of data bit 3 of the low byte
    accept(0, 16'hFFFF);
    vld[0] = 1'b0;
    check_span(0, 16'hFFFF, 0, 17);
    rst_n = 1'b0;
    #1;
    check_idle(0, "async_rst");
    @(negedge clk);
    check_idle(0, "rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "rst_rel");
    send_word(0, 16'h8001, 1'b0);

    // other bit widths
    send_word(1, 16'hC3A7, 1'b1);
    send_word(2, 16'hC3A7, 1'b1);

    // randomized words and idle gaps on every instance
    for (int k = 0; k < 24; k++) begin
      int d;
      d = k % 3;
      send_word(d, 16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
